// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter
// Shares one synchronous single-port SRAM between the core's instruction-fetch
// port and its load/store port. At most one access is granted per cycle and the
// owner of the read data returning on the following cycle is tracked.
// Optional feature macro: ARB_ROUND_ROBIN_EN (defined = alternate on conflict,
// undefined = fixed priority, data over instruction).
module riscv_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rstb,
  // instruction fetch port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // SRAM port
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_INSTR = 2'd1;
  localparam logic [1:0] OWN_DATA  = 2'd2;

  localparam logic [0:0] LAST_INSTR = 1'b0;
  localparam logic [0:0] LAST_DATA  = 1'b1;

  logic [1:0] rsp_own_reg, rsp_own_next;
  logic       rsp_wr_reg, rsp_wr_next;
  logic [0:0] last_reg, last_next;
  logic       d_win;

`ifdef ARB_ROUND_ROBIN_EN
  // On a conflict the requester that did not win most recently takes the slot.
  assign d_win = d_req & (~i_req | (last_reg == LAST_INSTR));
`else
  // Data always wins; fetch only proceeds when the load/store port is idle.
  assign d_win = d_req;
  // History is still tracked so both builds share the same state, but it does
  // not steer arbitration here.
  logic last_unused;
  assign last_unused = last_reg[0];
`endif

  assign d_gnt = d_win;
  assign i_gnt = i_req & ~d_win;

  // Drive the SRAM control pins from whichever requester holds the grant.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_be    = d_we ? d_be : '1;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt) begin
      m_en    = 1'b1;
      m_be    = '1;
      m_addr  = i_addr;
    end
  end

  // Work out who owns next cycle's response and update the arbitration history.
  always_comb begin
    rsp_own_next = OWN_NONE;
    rsp_wr_next  = 1'b0;
    last_next    = last_reg;
    if (d_gnt) begin
      rsp_own_next = OWN_DATA;
      rsp_wr_next  = d_we;
      last_next    = LAST_DATA;
    end else if (i_gnt) begin
      rsp_own_next = OWN_INSTR;
      last_next    = LAST_INSTR;
    end
  end

  // Response tracking state; reset discards any response still in flight.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rsp_own_reg <= OWN_NONE;
      rsp_wr_reg  <= 1'b0;
      last_reg    <= LAST_DATA;
    end else begin
      rsp_own_reg <= rsp_own_next;
      rsp_wr_reg  <= rsp_wr_next;
      last_reg    <= last_next;
    end
  end

  // Route returning SRAM data to its owner; store acknowledgements carry no data.
  always_comb begin
    i_rvalid = (rsp_own_reg == OWN_INSTR);
    d_rvalid = (rsp_own_reg == OWN_DATA);
    i_rdata  = i_rvalid ? m_rdata : '0;
    d_rdata  = (d_rvalid && !rsp_wr_reg) ? m_rdata : '0;
  end

endmodule
